// File: rtl/split_pkg.sv
// Shared types and helpers for the N-way buffered packet splitter.
package split_pkg;

  // Destination classes an input select can fall into.
  typedef enum logic [1:0] {
    SEL_UNICAST = 2'd0,
    SEL_BCAST   = 2'd1,
    SEL_INVALID = 2'd2
  } sel_class_t;

  // FIFO pointers carry one extra wrap bit above the address bits so that
  // full and empty can be told apart when the address bits are equal.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Unicast selects name a channel directly. The all-ones code means every
  // channel. Anything in between has no destination.
  function automatic sel_class_t classify_sel(input logic [31:0] sel,
                                              input logic [31:0] num_out,
                                              input logic [31:0] sel_w);
    logic [31:0] bcast_code;
    sel_class_t  cls;
    bcast_code = (32'd1 << sel_w) - 32'd1;
    if (sel < num_out) begin
      cls = SEL_UNICAST;
    end else if (sel == bcast_code) begin
      cls = SEL_BCAST;
    end else begin
      cls = SEL_INVALID;
    end
    return cls;
  endfunction

endpackage

// File: rtl/nway_split_buffered_fifo.sv
// Per-channel output FIFO. The head entry is read straight from registered
// storage, so there is no path from push to pop_data within a cycle.
module split_fifo
  import split_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  full,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  empty
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q;
  logic [PW-1:0]         rd_ptr_d;
  logic                  do_push_s;
  logic                  do_pop_s;

  assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                    (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  // Next storage and pointer values; pushes into a full FIFO and pops from
  // an empty one are ignored so the pointers can never cross.
  always_comb begin
    mem_d     = mem_q;
    do_push_s = push && !full;
    do_pop_s  = pop && !empty;
    if (do_push_s) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Storage and pointer registers; reset empties the FIFO and zeroes the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: rtl/nway_split_buffered.sv
// N-way packet splitter: routes each accepted packet to one output FIFO or
// to all of them, and drops and counts packets with no valid destination.
module nway_split_buffered
  import split_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int NUM_OUT    = 3,
  parameter int SEL_W      = 3,
  parameter int DEPTH      = 4,
  parameter int ERR_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic [SEL_W-1:0]              in_sel,
  output logic [NUM_OUT-1:0]            out_valid,
  input  logic [NUM_OUT-1:0]            out_ready,
  output logic [NUM_OUT*DATA_WIDTH-1:0] out_data,
  output logic                          err_pulse,
  output logic [ERR_W-1:0]              err_count
);

  sel_class_t            sel_class_s;
  logic [NUM_OUT-1:0]    sel_hot_s;
  logic [NUM_OUT-1:0]    full_s;
  logic [NUM_OUT-1:0]    empty_s;
  logic [NUM_OUT-1:0]    push_s;
  logic [NUM_OUT-1:0]    pop_s;
  logic [DATA_WIDTH-1:0] pop_data_s [NUM_OUT];
  logic                  ready_s;
  logic                  drop_s;
  logic                  err_pulse_q;
  logic                  err_pulse_d;
  logic [ERR_W-1:0]      err_count_q;
  logic [ERR_W-1:0]      err_count_d;

  // Select decode: class of the select plus a one-hot channel vector.
  always_comb begin
    sel_class_s = classify_sel(32'(in_sel), $unsigned(NUM_OUT), $unsigned(SEL_W));
    for (int i = 0; i < NUM_OUT; i++) begin
      sel_hot_s[i] = (in_sel == SEL_W'(i));
    end
  end

  // Ready and push generation. Ready uses the start-of-cycle full flags only,
  // so a pop in the same cycle never frees space for the current packet, and
  // a broadcast pushes to every FIFO or to none.
  always_comb begin
    ready_s = 1'b0;
    push_s  = {NUM_OUT{1'b0}};
    drop_s  = 1'b0;
    case (sel_class_s)
      SEL_UNICAST: begin
        ready_s = |(sel_hot_s & ~full_s);
        push_s  = sel_hot_s & {NUM_OUT{in_valid && ready_s && rst_n}};
      end
      SEL_BCAST: begin
        ready_s = ~|full_s;
        push_s  = {NUM_OUT{in_valid && ready_s && rst_n}};
      end
      SEL_INVALID: begin
        ready_s = 1'b1;
        drop_s  = in_valid && rst_n;
      end
      default: begin
        ready_s = 1'b0;
        push_s  = {NUM_OUT{1'b0}};
        drop_s  = 1'b0;
      end
    endcase
  end

  assign in_ready = rst_n && ready_s;

  // Drop reporting: pulse on every drop, count saturates at all ones.
  always_comb begin
    err_pulse_d = drop_s;
    if (drop_s && (err_count_q != {ERR_W{1'b1}})) begin
      err_count_d = err_count_q + {{(ERR_W-1){1'b0}}, 1'b1};
    end else begin
      err_count_d = err_count_q;
    end
  end

  // Error pulse and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse_q <= 1'b0;
      err_count_q <= {ERR_W{1'b0}};
    end else begin
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_chan
    split_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_s[g]),
      .push_data (in_data),
      .full      (full_s[g]),
      .pop       (pop_s[g]),
      .pop_data  (pop_data_s[g]),
      .empty     (empty_s[g])
    );

    assign out_valid[g]                          = !empty_s[g];
    assign pop_s[g]                              = out_ready[g] && !empty_s[g];
    assign out_data[g*DATA_WIDTH +: DATA_WIDTH]  = pop_data_s[g];
  end

endmodule

// File: tb/tb_nway_split_buffered.sv
// Directed test of nway_split_buffered with a queue scoreboard per channel.
module tb_nway_split_buffered;

  localparam int DW = 24;
  localparam int NO = 3;
  localparam int SW = 3;
  localparam int EW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid, in_ready;
  logic [DW-1:0]    in_data;
  logic [SW-1:0]    in_sel;
  logic [NO-1:0]    out_valid, out_ready;
  logic [NO*DW-1:0] out_data;
  logic             err_pulse;
  logic [EW-1:0]    err_count;

  logic             s_in_valid, s_in_ready;
  logic [DW-1:0]    s_in_data;
  logic [SW-1:0]    s_in_sel;
  logic [NO-1:0]    s_out_valid, s_out_ready;
  logic [NO*DW-1:0] s_out_data;
  logic             s_err_pulse;
  logic [1:0]       s_err_count;

  nway_split_buffered u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .err_pulse(err_pulse),
    .err_count(err_count)
  );

  nway_split_buffered #(.ERR_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .in_sel(s_in_sel), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_data(s_out_data), .err_pulse(s_err_pulse),
    .err_count(s_err_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] exp_q [NO][$];
  bit            exp_acc = 1'b0;
  bit            pulse_exp = 1'b0;
  int            cnt_exp = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected-response model: on each edge, a packet the bench expects to be
  // accepted is pushed into the queues of its destination channels.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NO; i++) exp_q[i].delete();
      pulse_exp = 1'b0;
      cnt_exp   = 0;
    end else begin
      int idx;
      idx = int'(in_sel);
      pulse_exp = 1'b0;
      if (in_valid && exp_acc) begin
        if (idx < NO) begin
          exp_q[idx].push_back(in_data);
        end else if (idx == 7) begin
          for (int i = 0; i < NO; i++) exp_q[i].push_back(in_data);
        end else begin
          pulse_exp = 1'b1;
          if (cnt_exp < 255) cnt_exp++;
        end
      end
    end
  end

  // Monitor: compares presented outputs with the scoreboard every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NO; i++) begin
        check($sformatf("valid_ch%0d", i), 128'(out_valid[i]), 128'(exp_q[i].size() != 0));
        if (out_valid[i] && out_ready[i] && exp_q[i].size() != 0) begin
          logic [DW-1:0] e;
          e = exp_q[i].pop_front();
          check($sformatf("data_ch%0d", i), 128'(out_data[i*DW +: DW]), 128'(e));
        end
      end
      check("err_pulse", 128'(err_pulse), 128'(pulse_exp));
      check("err_count", 128'(err_count), 128'(cnt_exp));
    end
  end

  // Offer one packet for one cycle and check the ready response.
  task automatic offer(input logic [SW-1:0] sel, input logic [DW-1:0] data,
                       input bit rdy, input string nm);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
    exp_acc  = rdy;
    #1;
    check(nm, 128'(in_ready), 128'(rdy));
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_acc  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    in_valid    = 1'b0;
    in_sel      = '0;
    in_data     = '0;
    out_ready   = 3'b111;
    s_in_valid  = 1'b0;
    s_in_sel    = '0;
    s_in_data   = '0;
    s_out_ready = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(3'b000));
    check("rst_out_data", 128'(out_data), 128'(0));
    check("rst_err_pulse", 128'(err_pulse), 128'(0));
    check("rst_err_count", 128'(err_count), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(0));
    rst_n = 1'b1;
    idle(1);

    // Unicast to each channel.
    offer(3'd0, 24'h0000A1, 1'b1, "t1_rdy0");
    check("t1_v0", 128'(out_valid), 128'(3'b001));
    check("t1_d0", 128'(out_data[23:0]), 128'(24'h0000A1));
    offer(3'd1, 24'h0000B2, 1'b1, "t1_rdy1");
    check("t1_v1", 128'(out_valid), 128'(3'b010));
    check("t1_d1", 128'(out_data[47:24]), 128'(24'h0000B2));
    offer(3'd2, 24'h0000C3, 1'b1, "t1_rdy2");
    check("t1_v2", 128'(out_valid), 128'(3'b100));
    check("t1_d2", 128'(out_data[71:48]), 128'(24'h0000C3));
    idle(1);
    check("t1_empty", 128'(out_valid), 128'(3'b000));

    // Stalled channel 1 fills, channel 0 still flows.
    out_ready = 3'b101;
    for (int k = 0; k < 4; k++) offer(3'd1, 24'h000010 + 24'(k), 1'b1, "t2_fill");
    offer(3'd1, 24'h000014, 1'b0, "t2_full_refuse");
    offer(3'd0, 24'h000020, 1'b1, "t2_other_ch");
    check("t2_v", 128'(out_valid), 128'(3'b011));
    check("t2_head1", 128'(out_data[47:24]), 128'(24'h000010));
    out_ready = 3'b111;
    idle(5);
    check("t2_drained", 128'(out_valid), 128'(3'b000));

    // Broadcast, then broadcast refused while channel 2 is full.
    offer(3'd7, 24'h5A5A5A, 1'b1, "t3_bcast_rdy");
    check("t3_bcast_v", 128'(out_valid), 128'(3'b111));
    check("t3_bcast_d", 128'(out_data), 128'({3{24'h5A5A5A}}));
    idle(1);
    out_ready = 3'b011;
    for (int k = 0; k < 4; k++) offer(3'd2, 24'h000030 + 24'(k), 1'b1, "t3_fill2");
    offer(3'd7, 24'h777777, 1'b0, "t3_bcast_refuse");
    check("t3_no_partial", 128'(out_valid), 128'(3'b100));

    // Full FIFO with a pop in the same cycle: push refused, then accepted.
    out_ready = 3'b111;
    offer(3'd2, 24'h000034, 1'b0, "t5_full_pop_refuse");
    out_ready = 3'b011;
    offer(3'd2, 24'h000034, 1'b1, "t5_retry_accept");
    offer(3'd2, 24'h000035, 1'b0, "t5_occ4_full");
    out_ready = 3'b111;
    idle(5);
    check("t5_drained", 128'(out_valid), 128'(3'b000));

    // Invalid selects are dropped and counted.
    offer(3'd4, 24'h444444, 1'b1, "t4_inv4_rdy");
    check("t4_pulse1", 128'(err_pulse), 128'(1));
    offer(3'd6, 24'h666666, 1'b1, "t4_inv6_rdy");
    check("t4_pulse2", 128'(err_pulse), 128'(1));
    check("t4_count2", 128'(err_count), 128'(2));
    idle(1);
    check("t4_pulse_off", 128'(err_pulse), 128'(0));
    check("t4_no_out", 128'(out_valid), 128'(3'b000));

    // Asynchronous reset while channel 0 holds data.
    out_ready = 3'b110;
    offer(3'd0, 24'h000040, 1'b1, "t6_fill_a");
    offer(3'd0, 24'h000041, 1'b1, "t6_fill_b");
    check("t6_held", 128'(out_valid), 128'(3'b001));
    in_valid = 1'b1;
    in_sel   = 3'd0;
    in_data  = 24'h000042;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 128'(out_valid), 128'(3'b000));
    check("t6_rst_ready", 128'(in_ready), 128'(0));
    check("t6_rst_data", 128'(out_data), 128'(0));
    check("t6_rst_count", 128'(err_count), 128'(0));
    in_valid = 1'b0;
    idle(2);
    rst_n     = 1'b1;
    out_ready = 3'b111;
    idle(1);
    offer(3'd1, 24'h000099, 1'b1, "t6_post_rdy");
    check("t6_post_v", 128'(out_valid), 128'(3'b010));
    check("t6_post_d", 128'(out_data[47:24]), 128'(24'h000099));
    idle(1);

    // Saturating error counter on the 2-bit instance.
    s_in_valid = 1'b1;
    s_in_sel   = 3'd5;
    #1;
    check("sat_rdy", 128'(s_in_ready), 128'(1));
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("sat_count_%0d", k), 128'(s_err_count), 128'((k < 3) ? k : 3));
      check($sformatf("sat_pulse_%0d", k), 128'(s_err_pulse), 128'(1));
    end
    s_in_valid = 1'b0;
    @(posedge clk); #1;
    check("sat_pulse_off", 128'(s_err_pulse), 128'(0));
    check("sat_hold", 128'(s_err_count), 128'(3));
    check("sat_no_out", 128'(s_out_valid), 128'(3'b000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nway_split_buffered.md
# nway_split_buffered

Clocked, parametrised N-way packet splitter for the PE datapath: accepts one packet plus a destination select per cycle over a valid/ready channel and routes it to one of `NUM_OUT` output channels, or to all of them. Each output has its own FIFO, so a stalled consumer blocks only packets addressed to it. Invalid selects are consumed, dropped and counted. It replaces the fixed three-way filter-row split where filter, ifmap and psum packets fan out to PE rows.

## Interface
- `DATA_WIDTH`, 24: packet width (3 × 8-bit filter values).
- `NUM_OUT`, 3: number of output channels; 2..16.
- `SEL_W`, 3: select width; must satisfy 2**SEL_W > NUM_OUT.
- `DEPTH`, 4: entries per output FIFO; power of two, ≥ 2.
- `ERR_W`, 8: error counter width.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  input packet present.
- `in_ready`  out  1  input packet accepted this cycle when `in_valid` is also high.
- `in_data`  in  DATA_WIDTH  packet.
- `in_sel`  in  SEL_W  destination select.
- `out_valid`  out  NUM_OUT  per-channel packet present.
- `out_ready`  in  NUM_OUT  per-channel consumer accepts.
- `out_data`  out  NUM_OUT*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `err_pulse`  out  1  registered one-cycle pulse: an invalid-select packet was dropped.
- `err_count`  out  ERR_W  saturating count of dropped packets.

## Operation
- Select classes:
  - UNICAST: 0..NUM_OUT-1.
  - BCAST: all ones (2**SEL_W-1).
  - INVALID: everything else. With the defaults, 0–2 are unicast, 3–6 are invalid and 7 is broadcast.
- `in_ready` is combinational from `in_sel` and the FIFO full flags:
  - UNICAST: `!full[in_sel]`.
  - BCAST: no FIFO is full.
  - INVALID: 1.
  - `in_ready` is 0 whenever `rst_n` is low.
- Producer rule: `in_data` and `in_sel` are held stable while `in_valid` is high and not yet accepted. `in_ready` never feeds back into `in_valid`.
- Transfer occurs when `in_valid && in_ready`:
  - UNICAST: push to that FIFO.
  - BCAST: push the same data to every FIFO in the same cycle. This is all-or-nothing; there is never a partial broadcast.
  - INVALID: discard the packet, assert `err_pulse` next cycle, and increment `err_count`. The count saturates at 2**ERR_W-1.
- Each output FIFO:
  - `out_valid[i] = !empty[i]`; `out_data[i]` = head entry.
  - Pop on `out_valid[i] && out_ready[i]`.
  - Order is preserved per channel; there is no ordering guarantee across channels.
- Full and empty flags are derived from read and write pointers of log2(DEPTH)+1 bits. The pointers wrap naturally; full means the low bits are equal and the MSBs differ.

## Timing
- Reset, asynchronous and taking effect immediately: all FIFOs empty, `out_valid` = 0, `out_data` = 0, `err_pulse` = 0, `err_count` = 0. Reset mid-transfer drops all buffered packets.
- Latency: a packet accepted at edge k appears on `out_valid` and `out_data` after edge k, so it is visible from cycle k+1. There is no combinational input-to-output path.
- Throughput: one input packet per cycle while the target FIFOs have space. Each output drains one per cycle.
- Full FIFO with a simultaneous pop: push is refused that cycle, because `in_ready` uses the start-of-cycle full flag. The packet is accepted next cycle.
- Empty FIFO with a simultaneous push: `out_valid` rises the next cycle; there is no bypass.
- Simultaneous push and pop on a non-full, non-empty FIFO: occupancy is unchanged.
- `err_count` at saturation: holds its value, and `err_pulse` still fires.

## Structure
- Package `split_pkg` holds:
  - `typedef enum {SEL_UNICAST, SEL_BCAST, SEL_INVALID} sel_class_t`.
  - A function `classify_sel(sel, num_out, sel_w)`.
  - The localparam helper for pointer width.
- Sub-module `split_fifo #(DATA_WIDTH, DEPTH)`, instantiated NUM_OUT times by a generate loop:
  - Ports: `clk`, `rst_n`, `push`, `push_data`, `full`, `pop`, `pop_data`, `empty`.
- The top level contains the select decode, the ready logic and the error counter.

## Test plan
- Reset, then send sel = 0, 1, 2 with data 0xA1, 0xB2, 0xC3 while all outputs are ready. Each appears only on its channel, one cycle after acceptance. `err_count` stays 0.
- Hold `out_ready[1]` = 0 and send 5 packets to sel 1. Four are accepted; on the fifth, `in_ready` drops. A sel-0 packet offered next is still accepted. After `out_ready[1]` rises, packets drain in order.
- Send sel = 7 with data 0x5A5A5A while all ready. All three channels present 0x5A5A5A in the same cycle. Then fill channel 2, send a broadcast, and check that `in_ready` = 0 and no channel receives it.
- Send sel = 4 and then sel = 6. Both are accepted, `err_pulse` fires twice, `err_count` = 2, and no output asserts. With ERR_W = 2, send 5 invalid packets: `err_count` saturates at 3.
- Full FIFO (4 entries) with `out_ready` high and a pending push in the same cycle: the pop happens and the push is refused. The push is accepted the next cycle, and occupancy ends at 4.
- Assert `rst_n` low asynchronously while channels hold data. `out_valid` clears immediately and `in_ready` = 0. After release, the first new packet is output correctly.
